uioreg_bridge_mc: RTL and testbench
===================================

// Module: uioreg_bridge_mc
// PURPOSE
//  Avalon-MM slave to custom-logic bridge with wait-states and variable read latency (con_rdvalid).
//  Adds NUM_IRQ edge-detected interrupt sources with sticky status and mask registers.
//  Sits between the HPS lightweight bus and synth register/voice logic.
// PARAMETERS
//  ADDRESS_WIDTH   14   slave/con address width
//  DATA_WIDTH      32   data width
//  NUM_IRQ         4    interrupt inputs, 1..DATA_WIDTH-1
//  TIMEOUT_CYCLES  255  RD_WAIT cycles before abort (UIO_RD_TIMEOUT_EN only)
// PORTS
//  clk               in   1    system clock
//  reset             in   1    synchronous, active-high
//  slave_address     in   AW   word address
//  slave_read        in   1    read request
//  slave_write       in   1    write request
//  slave_chipselect  in   1    qualifies read/write
//  slave_writedata   in   DW   write data
//  slave_readdata    out  DW   read data, registered
//  slave_waitrequest out  1    stall, combinational
//  slave_irq         out  1    level interrupt, registered
//  con_adrout        out  AW   latched address
//  con_dataout       out  DW   latched write data
//  con_write_out     out  1    1-cycle write strobe
//  con_read_out      out  1    1-cycle read strobe
//  con_datain        in   DW   read data from custom logic
//  con_rdvalid       in   1    con_datain valid
//  con_int_in_n      in   NUM_IRQ  active-low interrupt levels
// BEHAVIOUR
//  Reset: every output 0, state IDLE, status/mask/edge regs 0; pending transfer dropped, con_rdvalid ignored.
//  Map: addr all-ones = IRQ_STATUS (R, W1C); addr all-ones-1 = IRQ_MASK (R/W); all else passthrough.
//  req = slave_chipselect & (slave_read | slave_write); read has priority if both asserted.
//  slave_waitrequest = req & (state != DONE).
//  FSM IDLE->WR->DONE: on passthrough write, latch adr/data; con_write_out=1 in WR only. Done at cycle 2.
//  FSM IDLE->RD_WAIT->DONE: on passthrough read, latch adr; con_read_out=1 in first RD_WAIT cycle only.
//   con_rdvalid sampled every RD_WAIT cycle, incl. first; capture con_datain. Earliest done: cycle 2.
//  IDLE->DONE for register access: readdata or register update in the same cycle. Done at cycle 1.
//  DONE: waitrequest low for one cycle, then IDLE. slave_readdata holds until the next read completes.
//  IRQ: edge = prev_n & ~now_n (1-cycle delay reg) sets status[i].
//   W1C clears bits written 1; a set and a clear on the same bit in the same cycle: set wins.
//  slave_irq <= |(status & mask), so it follows a status/mask change by 1 cycle.
//  IRQ_STATUS reads: bits above NUM_IRQ read 0, except bit DW-1 (timeout flag). IRQ_MASK writes to bits >= NUM_IRQ are ignored.
//  con_adrout and con_dataout hold their last latched values in IDLE.
// CONFIGURATION
//  `UIO_RD_TIMEOUT_EN defined: an 8+ bit counter runs in RD_WAIT.
//   At TIMEOUT_CYCLES with no con_rdvalid: readdata=32'hDEADBEEF, status[DW-1] set (sticky, W1C), go to DONE.
//   status[DW-1] counts as a source only if mask[DW-1]=1.
//  Undefined: RD_WAIT waits indefinitely; status[DW-1] reads 0.
// STRUCTURE
//  Package uioreg_pkg: FSM state enum, REG_STATUS/REG_MASK offsets, TIMEOUT_DATA constant.
//  Sub-module uioreg_irq_ctrl: edge detect, status/mask regs, slave_irq.
// TESTING
//  Reset mid-RD_WAIT, then con_rdvalid=1 -> waitrequest 0, con_read_out 0, readdata unchanged (0).
//  Write 0x12 to addr 5 -> con_write_out 1 for exactly 1 cycle, adrout=5, dataout=0x12; waitrequest drops at cycle 2.
//  Read addr 7, con_rdvalid after 3 cycles with datain 0xCAFE -> readdata 0xCAFE; waitrequest high for 4 cycles.
//  mask=0x1; fall edge on con_int_in_n[0] -> slave_irq 1 two cycles later; W1C 0x1 -> irq 0.
//   Same-cycle new edge + W1C on bit 0 -> status stays 1.
//  Fall edge on bit 2 with mask=0 -> status 0x4, slave_irq stays 0.
//  With `UIO_RD_TIMEOUT_EN, no rdvalid -> readdata 0xDEADBEEF after 255 cycles, status bit 31 set.

Source files
------------

// File: rtl/uioreg_pkg.sv
// Shared definitions for the uioreg bridge slice.
//   state_t        : bridge transfer FSM states
//   REG_*_OFS      : register offsets counted down from the all-ones address
//   TIMEOUT_DATA   : read data returned when a custom-logic read is aborted
package uioreg_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR      = 2'd1,
    S_RD_WAIT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int unsigned REG_STATUS_OFS = 0;
  localparam int unsigned REG_MASK_OFS   = 1;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/uioreg_bridge_mc_if.sv
// Avalon-MM slave-side bus bundle for uioreg_bridge_mc.
//   slave_address/read/write/chipselect/writedata : master -> bridge
//   slave_readdata/waitrequest/irq                 : bridge -> master
interface uioreg_bridge_mc_if #(
  parameter int unsigned AW = 14,
  parameter int unsigned DW = 32
);
  logic [AW-1:0] slave_address;
  logic          slave_read;
  logic          slave_write;
  logic          slave_chipselect;
  logic [DW-1:0] slave_writedata;
  logic [DW-1:0] slave_readdata;
  logic          slave_waitrequest;
  logic          slave_irq;

  modport master (
    output slave_address, slave_read, slave_write, slave_chipselect, slave_writedata,
    input  slave_readdata, slave_waitrequest, slave_irq
  );

  modport slave (
    input  slave_address, slave_read, slave_write, slave_chipselect, slave_writedata,
    output slave_readdata, slave_waitrequest, slave_irq
  );
endinterface

// File: rtl/uioreg_irq_ctrl.sv
// Interrupt controller for the uioreg bridge.
// Falling-edge detect on active-low inputs, sticky W1C status, mask, and a
// registered level irq = |(status & mask).
// Optional macro UIO_RD_TIMEOUT_EN adds the read-timeout flag at bit DW-1.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   int_in_n      : active-low interrupt levels
//   w1c_en        : write-1-to-clear strobe for status (uses wr_lo/wr_top)
//   mask_we       : mask write strobe
//   wr_lo, wr_top : write data bits [NUM_IRQ-1:0] and [DATA_WIDTH-1]
//   timeout_set   : sets the timeout flag
//   status_rd     : status read view; mask_rd : mask read view
//   irq           : registered interrupt level
module uioreg_irq_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_IRQ    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_IRQ-1:0]    int_in_n,
  input  logic                  w1c_en,
  input  logic                  mask_we,
  input  logic [NUM_IRQ-1:0]    wr_lo,
  input  logic                  wr_top,
  input  logic                  timeout_set,
  output logic [DATA_WIDTH-1:0] status_rd,
  output logic [DATA_WIDTH-1:0] mask_rd,
  output logic                  irq
);

  logic [NUM_IRQ-1:0] prev_n;
  logic [NUM_IRQ-1:0] status;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] fall;
  logic [NUM_IRQ-1:0] clr;
  logic               tflag;
  logic               tmask;

  assign fall = prev_n & ~int_in_n;
  assign clr  = w1c_en ? wr_lo : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_n <= '0;
      status <= '0;
      mask   <= '0;
      irq    <= 1'b0;
    end else begin
      prev_n <= int_in_n;
      // Set is OR-ed after the clear so a same-cycle edge wins over W1C.
      status <= (status & ~clr) | fall;
      if (mask_we) mask <= wr_lo;
      irq <= (|(status & mask)) | (tflag & tmask);
    end
  end

`ifdef UIO_RD_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tflag <= 1'b0;
      tmask <= 1'b0;
    end else begin
      tflag <= (tflag & ~(w1c_en & wr_top)) | timeout_set;
      if (mask_we) tmask <= wr_top;
    end
  end
`else
  logic unused_tie;
  assign tflag      = 1'b0;
  assign tmask      = 1'b0;
  assign unused_tie = &{1'b0, timeout_set, wr_top};
`endif

  always_comb begin
    status_rd                = '0;
    status_rd[NUM_IRQ-1:0]   = status;
    status_rd[DATA_WIDTH-1]  = tflag;
    mask_rd                  = '0;
    mask_rd[NUM_IRQ-1:0]     = mask;
    mask_rd[DATA_WIDTH-1]    = tmask;
  end

endmodule

// File: rtl/uioreg_bridge_mc.sv
// Avalon-MM slave to custom-logic bridge with wait-states, variable read
// latency (con_rdvalid) and NUM_IRQ edge-detected interrupt sources.
// Optional macro UIO_RD_TIMEOUT_EN: aborts RD_WAIT after TIMEOUT_CYCLES,
// returning TIMEOUT_DATA and setting status bit DATA_WIDTH-1.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   bus            : Avalon slave bundle (uioreg_bridge_mc_if.slave)
//   con_adrout     : latched address      con_dataout  : latched write data
//   con_write_out  : 1-cycle write strobe con_read_out : 1-cycle read strobe
//   con_datain     : read data            con_rdvalid  : con_datain valid
//   con_int_in_n   : active-low interrupt levels
// Address map: all-ones = IRQ_STATUS (R/W1C), all-ones-1 = IRQ_MASK (R/W),
// everything else is passed through to the custom logic.
module uioreg_bridge_mc
  import uioreg_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 14,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_IRQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  uioreg_bridge_mc_if.slave        bus,
  output logic [ADDRESS_WIDTH-1:0] con_adrout,
  output logic [DATA_WIDTH-1:0]    con_dataout,
  output logic                     con_write_out,
  output logic                     con_read_out,
  input  logic [DATA_WIDTH-1:0]    con_datain,
  input  logic                     con_rdvalid,
  input  logic [NUM_IRQ-1:0]       con_int_in_n
);

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_STATUS =
    {ADDRESS_WIDTH{1'b1}} - ADDRESS_WIDTH'(REG_STATUS_OFS);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK =
    {ADDRESS_WIDTH{1'b1}} - ADDRESS_WIDTH'(REG_MASK_OFS);

  state_t                state, state_nxt;
  logic                  req, is_rd, hit_status, hit_mask, hit_reg;
  logic                  first_rd, timeout_hit, status_w1c, mask_we;
  logic [DATA_WIDTH-1:0] status_rd, mask_rd;

  assign req        = bus.slave_chipselect & (bus.slave_read | bus.slave_write);
  assign is_rd      = bus.slave_read;
  assign hit_status = (bus.slave_address == ADDR_STATUS);
  assign hit_mask   = (bus.slave_address == ADDR_MASK);
  assign hit_reg    = hit_status | hit_mask;

  assign bus.slave_waitrequest = req & (state != S_DONE);
  assign con_write_out         = (state == S_WR);
  assign con_read_out          = (state == S_RD_WAIT) & first_rd;

  assign status_w1c = (state == S_IDLE) & req & ~is_rd & hit_status;
  assign mask_we    = (state == S_IDLE) & req & ~is_rd & hit_mask;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          if (hit_reg)    state_nxt = S_DONE;
          else if (is_rd) state_nxt = S_RD_WAIT;
          else            state_nxt = S_WR;
        end
      end
      S_WR:      state_nxt = S_DONE;
      S_RD_WAIT: if (con_rdvalid || timeout_hit) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= S_IDLE;
      first_rd           <= 1'b0;
      con_adrout         <= '0;
      con_dataout        <= '0;
      bus.slave_readdata <= '0;
    end else begin
      state    <= state_nxt;
      first_rd <= (state == S_IDLE) && (state_nxt == S_RD_WAIT);
      if (state == S_IDLE && req && !hit_reg) begin
        con_adrout <= bus.slave_address;
        if (!is_rd) con_dataout <= bus.slave_writedata;
      end
      if (state == S_IDLE && req && hit_reg && is_rd)
        bus.slave_readdata <= hit_status ? status_rd : mask_rd;
      if (state == S_RD_WAIT) begin
        if (con_rdvalid)      bus.slave_readdata <= con_datain;
        else if (timeout_hit) bus.slave_readdata <= DATA_WIDTH'(TIMEOUT_DATA);
      end
    end
  end

`ifdef UIO_RD_TIMEOUT_EN
  localparam int unsigned TCW =
    (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TCW-1:0] to_cnt;

  // Counts RD_WAIT cycles from 0 in the first one; aborts in cycle TIMEOUT_CYCLES.
  always_ff @(posedge clk) begin
    if (reset || state != S_RD_WAIT) to_cnt <= '0;
    else                             to_cnt <= to_cnt + TCW'(1);
  end

  assign timeout_hit = (state == S_RD_WAIT) & ~con_rdvalid &
                       (to_cnt == TCW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  uioreg_irq_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_IRQ    (NUM_IRQ)
  ) u_irq (
    .clk         (clk),
    .reset       (reset),
    .int_in_n    (con_int_in_n),
    .w1c_en      (status_w1c),
    .mask_we     (mask_we),
    .wr_lo       (bus.slave_writedata[NUM_IRQ-1:0]),
    .wr_top      (bus.slave_writedata[DATA_WIDTH-1]),
    .timeout_set (timeout_hit),
    .status_rd   (status_rd),
    .mask_rd     (mask_rd),
    .irq         (bus.slave_irq)
  );

endmodule

// File: tb/tb_uioreg_bridge_mc.sv
// Self-checking bench for uioreg_bridge_mc: vector table, hand-written
// corner sequences (IRQ timing, reset during RD_WAIT, optional timeout) and
// a randomized run against a transaction-level model.
module tb_uioreg_bridge_mc;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int NI = 4;
  localparam logic [AW-1:0] A_STATUS = 14'h3FFF;
  localparam logic [AW-1:0] A_MASK   = 14'h3FFE;
`ifdef UIO_RD_TIMEOUT_EN
  localparam logic [DW-1:0] MASK_ALL = 32'h8000_000F;
`else
  localparam logic [DW-1:0] MASK_ALL = 32'h0000_000F;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] con_adrout;
  logic [DW-1:0] con_dataout;
  logic          con_write_out, con_read_out;
  logic [DW-1:0] con_datain;
  logic          con_rdvalid;
  logic [NI-1:0] con_int_in_n;

  uioreg_bridge_mc_if #(.AW(AW), .DW(DW)) bus ();

  uioreg_bridge_mc #(
    .ADDRESS_WIDTH  (AW),
    .DATA_WIDTH     (DW),
    .NUM_IRQ        (NI),
    .TIMEOUT_CYCLES (255)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .con_adrout    (con_adrout),
    .con_dataout   (con_dataout),
    .con_write_out (con_write_out),
    .con_read_out  (con_read_out),
    .con_datain    (con_datain),
    .con_rdvalid   (con_rdvalid),
    .con_int_in_n  (con_int_in_n)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int resp_delay = 0;           // -1: custom logic never answers
  logic [DW-1:0] resp_mem [int];
  int wr_pulses = 0;
  int rd_pulses = 0;

  function automatic logic [DW-1:0] defval(input logic [AW-1:0] a);
    return 32'hA5A5_0000 | 32'(a);
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Custom-logic side: stores strobed writes, counts strobe cycles.
  always @(negedge clk) begin
    if (con_write_out) begin
      wr_pulses++;
      resp_mem[int'(con_adrout)] = con_dataout;
    end
    if (con_read_out) rd_pulses++;
  end

  // Custom-logic read responder: answers resp_delay cycles after the strobe.
  initial begin : responder
    int d;
    logic [AW-1:0] a;
    con_rdvalid = 1'b0;
    con_datain  = '0;
    forever begin
      @(negedge clk);
      if (con_read_out) begin
        d = resp_delay;
        a = con_adrout;
        if (d >= 0) begin
          if (d > 0) begin
            repeat (d) @(posedge clk);
            #1;
          end
          con_datain  = resp_mem.exists(int'(a)) ? resp_mem[int'(a)] : defval(a);
          con_rdvalid = 1'b1;
          @(posedge clk);
          #1;
          con_rdvalid = 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic xfer(input logic rd, input logic wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [NI-1:0] fall,
                      output logic [DW-1:0] rdata, output int waits);
    logic done;
    @(posedge clk);
    #1;
    con_int_in_n = con_int_in_n & ~fall;
    bus.slave_chipselect = 1'b1;
    bus.slave_read       = rd;
    bus.slave_write      = wr;
    bus.slave_address    = addr;
    bus.slave_writedata  = wdata;
    waits = 0;
    done  = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!bus.slave_waitrequest) begin
        done = 1'b1;
        break;
      end
      waits++;
      @(posedge clk);
      #1;
    end
    check("xfer_done", 32'(done), 32'd1);
    rdata = bus.slave_readdata;
    @(posedge clk);
    #1;
    bus.slave_chipselect = 1'b0;
    bus.slave_read       = 1'b0;
    bus.slave_write      = 1'b0;
  endtask

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            delay;
    logic          chk_rd;
    logic [DW-1:0] exp_rd;
    int            exp_waits;
    string         name;
  } vec_t;

  vec_t vecs[$];

  // Transaction-level model state for the random run.
  logic [NI-1:0] m_status, m_mask, m_lvl;
  logic          m_tflag, m_tmask;
  logic [DW-1:0] m_mem [int];

  initial begin : main
    logic [DW-1:0] rdata, exp, clr;
    int waits, w0, r0, kind, exp_waits, d;
    logic [AW-1:0] a;
    logic [NI-1:0] fall, eff;
    logic is_reg, exp_irq;

    reset = 1'b1;
    bus.slave_chipselect = 1'b0;
    bus.slave_read       = 1'b0;
    bus.slave_write      = 1'b0;
    bus.slave_address    = '0;
    bus.slave_writedata  = '0;
    con_int_in_n         = '1;
    do_reset();

    @(negedge clk);
    check("rst_readdata", bus.slave_readdata, '0);
    check("rst_waitreq", 32'(bus.slave_waitrequest), 32'd0);
    check("rst_irq", 32'(bus.slave_irq), 32'd0);
    check("rst_adrout", 32'(con_adrout), 32'd0);
    check("rst_dataout", con_dataout, '0);
    check("rst_wrout", 32'(con_write_out), 32'd0);
    check("rst_rdout", 32'(con_read_out), 32'd0);

    vecs.push_back('{1'b0, 1'b1, 14'd5,  32'h12,        0, 1'b0, 32'h0,         2, "wr_a5"});
    vecs.push_back('{1'b0, 1'b1, 14'd7,  32'hCAFE,      0, 1'b0, 32'h0,         2, "wr_a7"});
    vecs.push_back('{1'b1, 1'b0, 14'd7,  32'h0,         2, 1'b1, 32'hCAFE,      4, "rd_a7_lat3"});
    vecs.push_back('{1'b1, 1'b0, 14'd5,  32'h0,         0, 1'b1, 32'h12,        2, "rd_a5_lat1"});
    vecs.push_back('{1'b1, 1'b0, 14'd9,  32'h0,         1, 1'b1, 32'hA5A5_0009, 3, "rd_a9_lat2"});
    vecs.push_back('{1'b0, 1'b1, A_MASK, 32'hFFFF_FFFF, 0, 1'b0, 32'h0,         1, "wr_mask_all"});
    vecs.push_back('{1'b1, 1'b0, A_MASK, 32'h0,         0, 1'b1, MASK_ALL,      1, "rd_mask"});
    vecs.push_back('{1'b1, 1'b1, A_MASK, 32'h0,         0, 1'b1, MASK_ALL,      1, "rdwr_mask_prio"});
    vecs.push_back('{1'b1, 1'b0, A_MASK, 32'h0,         0, 1'b1, MASK_ALL,      1, "rd_mask_kept"});
    vecs.push_back('{1'b0, 1'b1, A_MASK, 32'h1,         0, 1'b0, 32'h0,         1, "wr_mask_1"});
    vecs.push_back('{1'b1, 1'b0, A_STATUS, 32'h0,       0, 1'b1, 32'h0,         1, "rd_status_0"});
    vecs.push_back('{1'b1, 1'b1, 14'd11, 32'h77,        0, 1'b1, 32'hA5A5_000B, 2, "rdwr_pass_prio"});

    foreach (vecs[i]) begin
      resp_delay = vecs[i].delay;
      is_reg = (vecs[i].addr == A_STATUS) || (vecs[i].addr == A_MASK);
      w0 = wr_pulses;
      r0 = rd_pulses;
      xfer(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, '0, rdata, waits);
      check({vecs[i].name, "_waits"}, 32'(waits), 32'(vecs[i].exp_waits));
      if (vecs[i].chk_rd) check({vecs[i].name, "_data"}, rdata, vecs[i].exp_rd);
      check({vecs[i].name, "_wrpulse"}, 32'(wr_pulses - w0),
            32'((vecs[i].wr && !vecs[i].rd && !is_reg) ? 1 : 0));
      check({vecs[i].name, "_rdpulse"}, 32'(rd_pulses - r0),
            32'((vecs[i].rd && !is_reg) ? 1 : 0));
      if (!is_reg) begin
        check({vecs[i].name, "_adrout"}, 32'(con_adrout), 32'(vecs[i].addr));
        if (vecs[i].wr && !vecs[i].rd)
          check({vecs[i].name, "_dataout"}, con_dataout, vecs[i].wdata);
      end
    end
    resp_delay = 0;

    // IRQ timing with mask = 0x1: fall edge -> irq two cycles later.
    @(posedge clk); #1;
    con_int_in_n[0] = 1'b0;
    @(negedge clk); check("irq_edge_c0", 32'(bus.slave_irq), 32'd0);
    @(negedge clk); check("irq_edge_c1", 32'(bus.slave_irq), 32'd0);
    @(negedge clk); check("irq_edge_c2", 32'(bus.slave_irq), 32'd1);
    xfer(1'b0, 1'b1, A_STATUS, 32'h1, '0, rdata, waits);
    check("irq_w1c_clears", 32'(bus.slave_irq), 32'd0);
    con_int_in_n = '1;
    repeat (2) @(posedge clk);

    // New edge and W1C on the same bit in the same cycle: set wins.
    xfer(1'b1, 1'b0, A_STATUS, 32'h0, 4'b0001, rdata, waits);
    check("st_rd_before_set", rdata, 32'h0);
    con_int_in_n = '1;
    xfer(1'b0, 1'b1, A_STATUS, 32'h1, 4'b0001, rdata, waits);
    xfer(1'b1, 1'b0, A_STATUS, 32'h0, '0, rdata, waits);
    check("st_set_wins", rdata, 32'h1);
    check("st_set_wins_irq", 32'(bus.slave_irq), 32'd1);
    xfer(1'b0, 1'b1, A_STATUS, 32'h1, '0, rdata, waits);
    con_int_in_n = '1;

    // Masked source: status records, irq stays low.
    xfer(1'b0, 1'b1, A_MASK, 32'h0, '0, rdata, waits);
    @(posedge clk); #1;
    con_int_in_n[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("irq_masked_low", 32'(bus.slave_irq), 32'd0);
    end
    xfer(1'b1, 1'b0, A_STATUS, 32'h0, '0, rdata, waits);
    check("st_masked_bit2", rdata, 32'h4);
    con_int_in_n = '1;

    // Reset during RD_WAIT, then a late con_rdvalid must be ignored.
    resp_delay = 4;
    @(posedge clk); #1;
    bus.slave_chipselect = 1'b1;
    bus.slave_read       = 1'b1;
    bus.slave_address    = 14'd7;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    bus.slave_chipselect = 1'b0;
    bus.slave_read       = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    check("rstrd_rdvalid_seen", 32'(con_rdvalid), 32'd1);
    @(negedge clk);
    check("rstrd_waitreq", 32'(bus.slave_waitrequest), 32'd0);
    check("rstrd_rdout", 32'(con_read_out), 32'd0);
    check("rstrd_readdata", bus.slave_readdata, '0);
    @(negedge clk);
    check("rstrd_readdata_hold", bus.slave_readdata, '0);
    check("rstrd_rdout_hold", 32'(con_read_out), 32'd0);
    resp_delay = 0;

`ifdef UIO_RD_TIMEOUT_EN
    resp_delay = -1;
    xfer(1'b1, 1'b0, 14'd9, 32'h0, '0, rdata, waits);
    check("to_data", rdata, 32'hDEAD_BEEF);
    check("to_waits", 32'(waits), 32'd256);
    resp_delay = 0;
    xfer(1'b1, 1'b0, A_STATUS, 32'h0, '0, rdata, waits);
    check("to_status", rdata, 32'h8000_0000);
    check("to_irq_masked", 32'(bus.slave_irq), 32'd0);
    xfer(1'b0, 1'b1, A_MASK, 32'h8000_0000, '0, rdata, waits);
    check("to_irq_unmasked", 32'(bus.slave_irq), 32'd1);
    xfer(1'b0, 1'b1, A_STATUS, 32'h8000_0000, '0, rdata, waits);
    check("to_irq_cleared", 32'(bus.slave_irq), 32'd0);
    xfer(1'b1, 1'b0, A_STATUS, 32'h0, '0, rdata, waits);
    check("to_status_cleared", rdata, 32'h0);
    xfer(1'b0, 1'b1, A_MASK, 32'h0, '0, rdata, waits);
`endif

    // Randomized traffic vs. transaction-level model (state is post-reset).
    m_status = '0; m_mask = '0; m_lvl = '1; m_tflag = 1'b0; m_tmask = 1'b0;
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 5);
      fall = ($urandom_range(0, 2) == 0) ? NI'($urandom) : '0;
      eff  = fall & m_lvl;
      a    = 14'h100 + 14'($urandom_range(0, 15));
      d    = $urandom_range(0, 4);
      clr  = '0;
      exp  = '0;
      resp_delay = d;
      case (kind)
        0: begin
          rdata = $urandom;
          m_mem[int'(a)] = rdata;
          xfer(1'b0, 1'b1, a, rdata, fall, rdata, waits);
          exp_waits = 2;
        end
        1: begin
          exp = m_mem.exists(int'(a)) ? m_mem[int'(a)] : defval(a);
          xfer(1'b1, 1'b0, a, 32'h0, fall, rdata, waits);
          check("rnd_pass_rd", rdata, exp);
          exp_waits = d + 2;
        end
        2: begin
          exp = $urandom;
          xfer(1'b0, 1'b1, A_MASK, exp, fall, rdata, waits);
          m_mask = exp[NI-1:0];
`ifdef UIO_RD_TIMEOUT_EN
          m_tmask = exp[31];
`endif
          exp_waits = 1;
        end
        3: begin
          exp[NI-1:0] = m_mask;
          exp[31]     = m_tmask;
          xfer(1'b1, 1'b0, A_MASK, 32'h0, fall, rdata, waits);
          check("rnd_mask_rd", rdata, exp);
          exp_waits = 1;
        end
        4: begin
          exp[NI-1:0] = m_status;
          exp[31]     = m_tflag;
          xfer(1'b1, 1'b0, A_STATUS, 32'h0, fall, rdata, waits);
          check("rnd_status_rd", rdata, exp);
          exp_waits = 1;
        end
        default: begin
          clr = $urandom;
          xfer(1'b0, 1'b1, A_STATUS, clr, fall, rdata, waits);
          exp_waits = 1;
        end
      endcase
      m_status = (m_status & ~clr[NI-1:0]) | eff;
      m_lvl    = m_lvl & ~fall;
      check("rnd_waits", 32'(waits), 32'(exp_waits));
      exp_irq = (|(m_status & m_mask)) | (m_tflag & m_tmask);
      check("rnd_irq", 32'(bus.slave_irq), 32'(exp_irq));
      if ($urandom_range(0, 1) == 1) begin
        con_int_in_n = '1;
        m_lvl = '1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule
